pc_fetch_stage: RTL and testbench

- Program-counter and instruction-fetch stage directly upstream/downstream of the 16-bit two-input next-PC mux.
- Produces `pc_plus`, which feeds the mux's sequential input. Consumes the mux output `next_pc` when a redirect (`pc_load`) is asserted.
- Holds PC, handshakes with instruction memory, and presents one fetched instruction to decode with valid/stall control.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/pc_reg.sv | 26 ++
 rtl/pc_fetch_stage.sv | 129 ++++++++++++
 tb/tb_pc_fetch_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default sizes for the fetch stage
package fetch_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam int          PC_W     = 16;
    localparam int          INSTR_W  = 16;
    localparam int          PC_INC   = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with load enable and sequential-increment output
module pc_reg #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               PC_INC   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_plus
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

    // Wraps modulo 2^WIDTH; no overflow indication is wanted.
    assign q_plus = q + WIDTH'(PC_INC);

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC/fetch FSM with redirect capture; PC_ALIGN_CHECK_EN adds misalign_err
module pc_fetch_stage #(
    parameter int               WIDTH    = fetch_pkg::PC_W,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(fetch_pkg::RESET_PC),
    parameter int               PC_INC   = fetch_pkg::PC_INC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             pc_load,
    input  logic             stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] instr,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misalign_err,
`endif
    output logic             instr_valid
);

    import fetch_pkg::IDLE;
    import fetch_pkg::REQ;
    import fetch_pkg::HOLD;

    logic [1:0]       state;
    logic             redir_flag;
    logic [WIDTH-1:0] redir_pc;
    logic             pc_en;
    logic [WIDTH-1:0] pc_target;
    logic [WIDTH-1:0] pc_d;

    always_comb begin
        pc_en     = 1'b0;
        pc_target = pc_plus;
        case (state)
            REQ: begin
                // A same-cycle pc_load beats an older captured redirect.
                if (imem_ack) begin
                    if (pc_load) begin
                        pc_en     = 1'b1;
                        pc_target = next_pc;
                    end else if (redir_flag) begin
                        pc_en     = 1'b1;
                        pc_target = redir_pc;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_en     = 1'b1;
                    pc_target = pc_load ? next_pc : pc_plus;
                end
            end
            default: ;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_hit;
    assign misalign_hit = pc_en & pc_target[0];
    assign pc_d         = {pc_target[WIDTH-1:1], 1'b0};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= misalign_hit;
        end
    end
`else
    assign pc_d = pc_target;
`endif

    pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc_reg (
        .clock  (clock),
        .reset  (reset),
        .load   (pc_en),
        .d      (pc_d),
        .q      (pc),
        .q_plus (pc_plus)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            redir_flag  <= 1'b0;
            redir_pc    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        if (!pc_load && !redir_flag) begin
                            instr       <= imem_rdata;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                        redir_flag <= 1'b0;
                    end else if (pc_load) begin
                        redir_pc   <= next_pc;
                        redir_flag <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Derived from state so an asynchronous reset drops the request at once.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - vector table plus directed sequences for pc_fetch_stage
module tb_pc_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] next_pc = '0;
    logic        pc_load = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] pc, pc_plus, instr;
    logic        instr_valid;

    logic        w_ack = 1'b0;
    logic [15:0] w_rdata = '0;
    logic [15:0] w_next_pc = '0;
    logic        w_pc_load = 1'b0;
    logic        w_stall = 1'b0;
    logic        w_req;
    logic [15:0] w_addr, w_pc, w_pc_plus, w_instr;
    logic        w_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_err;
    logic        w_misalign_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pc_fetch_stage dut (
        .clock       (clock),
        .reset       (reset),
        .next_pc     (next_pc),
        .pc_load     (pc_load),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .instr       (instr),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .instr_valid (instr_valid)
    );

    pc_fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clock       (clock),
        .reset       (reset),
        .next_pc     (w_next_pc),
        .pc_load     (w_pc_load),
        .stall       (w_stall),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata),
        .pc          (w_pc),
        .pc_plus     (w_pc_plus),
        .instr       (w_instr),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_err(w_misalign_err),
`endif
        .instr_valid (w_valid)
    );

    typedef struct {
        logic        stall;
        logic        pc_load;
        logic [15:0] next_pc;
        logic        ack;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_pc;
        logic [15:0] e_pcp;
        logic [15:0] e_instr;
        logic        e_valid;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic s, logic pl, logic [15:0] np, logic a, logic [15:0] rd,
                                logic er, logic [15:0] ep, logic [15:0] epp,
                                logic [15:0] ei, logic ev);
        vec_t v;
        v.stall = s; v.pc_load = pl; v.next_pc = np; v.ack = a; v.rdata = rd;
        v.e_req = er; v.e_pc = ep; v.e_pcp = epp; v.e_instr = ei; v.e_valid = ev;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [15:0] exp_odd_a;
    logic [15:0] exp_odd_b;

    initial begin
        //             stall pl  next_pc  ack rdata     req pc       pc_plus  instr    valid
        tbl[0]  = mk(0, 0, 16'h0000, 1, 16'hFFFF, 0, 16'h0000, 16'h0002, 16'h0000, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0002, 16'h0000, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 1, 16'h1234, 1, 16'h0000, 16'h0002, 16'h0000, 0);
        tbl[3]  = mk(1, 1, 16'h0300, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h1234, 1);
        for (int i = 4; i < 8; i++)
            tbl[i] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h1234, 1);
        tbl[8]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h1234, 1);
        tbl[9]  = mk(0, 0, 16'h0000, 1, 16'h5678, 1, 16'h0002, 16'h0004, 16'h1234, 0);
        tbl[10] = mk(0, 1, 16'h00A0, 0, 16'h0000, 0, 16'h0002, 16'h0004, 16'h5678, 1);
        tbl[11] = mk(0, 1, 16'h0010, 1, 16'h0001, 1, 16'h00A0, 16'h00A2, 16'h5678, 0);
        tbl[12] = mk(0, 1, 16'h0300, 0, 16'h0000, 1, 16'h0010, 16'h0012, 16'h5678, 0);
        tbl[13] = mk(0, 1, 16'h0200, 0, 16'h0000, 1, 16'h0010, 16'h0012, 16'h5678, 0);
        tbl[14] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0012, 16'h5678, 0);
        tbl[15] = mk(0, 0, 16'h0000, 1, 16'hBEEF, 1, 16'h0010, 16'h0012, 16'h5678, 0);
        tbl[16] = mk(0, 0, 16'h0000, 1, 16'hCAFE, 1, 16'h0200, 16'h0202, 16'h5678, 0);
        tbl[17] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0200, 16'h0202, 16'hCAFE, 1);
        tbl[18] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0202, 16'h0204, 16'hCAFE, 0);

`ifdef PC_ALIGN_CHECK_EN
        exp_odd_a = 16'h0100;
        exp_odd_b = 16'h0300;
`else
        exp_odd_a = 16'h0101;
        exp_odd_b = 16'h0301;
`endif

        // Reset values on both instances
        step();
        step();
        chk("rst_req", {15'd0, imem_req}, 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_valid", {15'd0, instr_valid}, 16'h0000);
        chk("rst_wrap_pc", w_pc, 16'hFFFE);
        reset = 1'b0;

        // Wrap-around on the RESET_PC=FFFE instance
        chk("wrap_idle_req", {15'd0, w_req}, 16'h0000);
        step();
        chk("wrap_req", {15'd0, w_req}, 16'h0001);
        chk("wrap_addr0", w_addr, 16'hFFFE);
        chk("wrap_pc_plus", w_pc_plus, 16'h0000);
        w_ack = 1'b1; w_rdata = 16'h1111;
        step();
        w_ack = 1'b0;
        chk("wrap_valid", {15'd0, w_valid}, 16'h0001);
        chk("wrap_instr", w_instr, 16'h1111);
        step();
        chk("wrap_req2", {15'd0, w_req}, 16'h0001);
        chk("wrap_addr1", w_addr, 16'h0000);

        // Main table from a fresh reset
        do_reset();
        for (int i = 0; i < 19; i++) begin
            stall = tbl[i].stall; pc_load = tbl[i].pc_load; next_pc = tbl[i].next_pc;
            imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), {15'd0, imem_req}, {15'd0, tbl[i].e_req});
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_pc_plus", i), pc_plus, tbl[i].e_pcp);
            chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
            chk($sformatf("v%0d_valid", i), {15'd0, instr_valid}, {15'd0, tbl[i].e_valid});
            if (tbl[i].e_req)
                chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_pc);
`ifdef PC_ALIGN_CHECK_EN
            chk($sformatf("v%0d_mis", i), {15'd0, misalign_err}, 16'h0000);
`endif
            step();
        end
        stall = 1'b0; pc_load = 1'b0; imem_ack = 1'b0; next_pc = '0;

        // Reset in REQ, late ack right after release
        chk("pre_rst_req", {15'd0, imem_req}, 16'h0001);
        reset = 1'b1;
        #1;
        chk("async_req", {15'd0, imem_req}, 16'h0000);
        chk("async_pc", pc, 16'h0000);
        step();
        reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        #1;
        chk("late_ack_req", {15'd0, imem_req}, 16'h0000);
        step();
        imem_ack = 1'b0;
        chk("late_ack_valid", {15'd0, instr_valid}, 16'h0000);
        chk("late_ack_instr", instr, 16'h0000);
        chk("late_ack_addr", imem_addr, 16'h0000);

        // Odd redirect with same-cycle ack, then odd captured redirect
        pc_load = 1'b1; next_pc = 16'h0101; imem_ack = 1'b1; imem_rdata = 16'h7777;
        step();
        pc_load = 1'b0; imem_ack = 1'b0;
        chk("odd_a_pc", pc, exp_odd_a);
`ifdef PC_ALIGN_CHECK_EN
        chk("odd_a_mis", {15'd0, misalign_err}, 16'h0001);
`endif
        step();
`ifdef PC_ALIGN_CHECK_EN
        chk("odd_a_mis_off", {15'd0, misalign_err}, 16'h0000);
`endif
        pc_load = 1'b1; next_pc = 16'h0301;
        step();
        pc_load = 1'b0;
        step();
        imem_ack = 1'b1; imem_rdata = 16'h8888;
        step();
        imem_ack = 1'b0;
        chk("odd_b_pc", pc, exp_odd_b);
`ifdef PC_ALIGN_CHECK_EN
        chk("odd_b_mis", {15'd0, misalign_err}, 16'h0001);
`endif
        step();
`ifdef PC_ALIGN_CHECK_EN
        chk("odd_b_mis_off", {15'd0, misalign_err}, 16'h0000);
`endif
        chk("odd_valid", {15'd0, instr_valid}, 16'h0000);
        chk("odd_addr", imem_addr, exp_odd_b);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
